// File: rtl/warp_arbiter.sv
// warp_arbiter: round-robin owner of one core's pipeline among NUM_WARPS warps.
// Define WARP_ARBITER_TIMEOUT_EN to force a switch after MAX_RUN cycles of residency.
module warp_arbiter #(
    parameter int NUM_WARPS = 4,
    parameter int MAX_RUN   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_WARPS-1:0]         warp_active,
    input  logic [NUM_WARPS-1:0]         warp_stall,
    input  logic [NUM_WARPS-1:0]         warp_done,
    input  logic                         switch_ok,
    output logic [$clog2(NUM_WARPS)-1:0] warp_select,
    output logic                         warp_valid,
    output logic                         switch_pulse,
    output logic                         all_done
);
    localparam int IW = $clog2(NUM_WARPS);

    if (NUM_WARPS < 2 || NUM_WARPS > 8 || (1 << IW) != NUM_WARPS || MAX_RUN < 2 || MAX_RUN > 255)
        $error("warp_arbiter: parameter out of range");

    typedef enum logic [1:0] {IDLE, SELECT, RUN, DONE} state_t;
    state_t state;

    logic [NUM_WARPS-1:0] elig;
    logic                 pend;
    logic                 found;
    logic                 timeout;
    logic [IW-1:0]        nxt;
    logic [IW-1:0]        idx;

    // Current warp is visited last, so a different warp always wins when one is eligible.
    always_comb begin
        elig  = warp_active & ~warp_done & ~warp_stall;
        pend  = |(warp_active & ~warp_done);
        found = 1'b0;
        nxt   = warp_select;
        idx   = '0;
        for (int k = 1; k <= NUM_WARPS; k++) begin
            idx = warp_select + IW'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                nxt   = idx;
            end
        end
    end

`ifdef WARP_ARBITER_TIMEOUT_EN
    logic [7:0] run_cnt;
    assign timeout = run_cnt == 8'(MAX_RUN - 1) && switch_ok && found && nxt != warp_select;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            warp_select  <= '0;
            warp_valid   <= 1'b0;
            switch_pulse <= 1'b0;
            all_done     <= 1'b0;
`ifdef WARP_ARBITER_TIMEOUT_EN
            run_cnt      <= '0;
`endif
        end else begin
            switch_pulse <= 1'b0;
            case (state)
                IDLE: if (start) state <= SELECT;
                SELECT: begin
                    if (!start) begin
                        state <= IDLE;
                    end else if (found) begin
                        state        <= RUN;
                        warp_select  <= nxt;
                        warp_valid   <= 1'b1;
                        switch_pulse <= nxt != warp_select;
`ifdef WARP_ARBITER_TIMEOUT_EN
                        run_cnt      <= '0;
`endif
                    end else if (!pend) begin
                        state    <= DONE;
                        all_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (!start || warp_done[warp_select] || (warp_stall[warp_select] && switch_ok) || timeout) begin
                        state      <= start ? SELECT : IDLE;
                        warp_valid <= 1'b0;
                    end
`ifdef WARP_ARBITER_TIMEOUT_EN
                    else if (run_cnt != 8'(MAX_RUN - 1)) begin
                        run_cnt <= run_cnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    if (!start) begin
                        state    <= IDLE;
                        all_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_warp_arbiter.sv
// tb_warp_arbiter: directed vector table plus reset and residency-timeout sequences.
module tb_warp_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] warp_active = 4'h0;
    logic [3:0] warp_stall = 4'h0;
    logic [3:0] warp_done = 4'h0;
    logic       switch_ok = 1'b0;
    logic [1:0] warp_select;
    logic       warp_valid;
    logic       switch_pulse;
    logic       all_done;
    int         checks = 0;
    int         errors = 0;

    warp_arbiter #(.NUM_WARPS(4), .MAX_RUN(4)) dut (
        .clk(clk), .reset(reset), .start(start), .warp_active(warp_active),
        .warp_stall(warp_stall), .warp_done(warp_done), .switch_ok(switch_ok),
        .warp_select(warp_select), .warp_valid(warp_valid),
        .switch_pulse(switch_pulse), .all_done(all_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic [3:0] act;
        logic [3:0] stl;
        logic [3:0] dn;
        logic       ok;
        logic [1:0] sel;
        logic       v;
        logic       p;
        logic       ad;
    } vec_t;

    vec_t tbl[28];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic count_run(input string name, input int exp_pulses);
        int pulses = 0;
        int low_valid = 0;
        repeat (20) begin
            step();
            pulses += int'(switch_pulse);
            low_valid += int'(!warp_valid && exp_pulses == 0);
        end
        check({name, "_pulses"}, pulses, exp_pulses);
        check({name, "_valid_drops"}, low_valid, 0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'hf, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'hf, 4'h0, 4'h0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 4'hf, 4'h0, 4'h0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 4'hf, 4'h2, 4'h0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 4'hf, 4'h2, 4'h0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 4'hf, 4'h2, 4'h0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 4'hf, 4'h0, 4'h4, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'hf, 4'h0, 4'h4, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 4'hf, 4'h0, 4'hc, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 4'hf, 4'h0, 4'hc, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 4'hf, 4'h0, 4'hd, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 4'hf, 4'h0, 4'hd, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 4'hf, 4'h2, 4'hf, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 4'hf, 4'h0, 4'hf, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 4'hf, 4'h0, 4'hf, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 4'hf, 4'h0, 4'h0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 4'h2, 4'h0, 4'h0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 4'h2, 4'h0, 4'h0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 4'h2, 4'h0, 4'h0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 4'h5, 4'h4, 4'h1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{1'b1, 4'h5, 4'h4, 4'h1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{1'b1, 4'h5, 4'h4, 4'h1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[22] = '{1'b1, 4'h5, 4'h0, 4'h1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0};
        tbl[23] = '{1'b1, 4'hd, 4'h1, 4'h1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
        tbl[24] = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[25] = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[26] = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1};
        tbl[27] = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};

        #1;
        check("reset_sel", int'(warp_select), 0);
        check("reset_valid", int'(warp_valid), 0);
        check("reset_pulse", int'(switch_pulse), 0);
        check("reset_all_done", int'(all_done), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 28; i++) begin
            start       = tbl[i].st;
            warp_active = tbl[i].act;
            warp_stall  = tbl[i].stl;
            warp_done   = tbl[i].dn;
            switch_ok   = tbl[i].ok;
            step();
            check($sformatf("v%0d_sel", i), int'(warp_select), int'(tbl[i].sel));
            check($sformatf("v%0d_valid", i), int'(warp_valid), int'(tbl[i].v));
            check($sformatf("v%0d_pulse", i), int'(switch_pulse), int'(tbl[i].p));
            check($sformatf("v%0d_all_done", i), int'(all_done), int'(tbl[i].ad));
        end

        // Asynchronous reset while resident on warp 1.
        do_reset();
        @(posedge clk);
        #1;
        start = 1'b1; warp_active = 4'hf; warp_stall = 4'h0; warp_done = 4'h0; switch_ok = 1'b0;
        step();
        step();
        check("pre_reset_sel", int'(warp_select), 1);
        check("pre_reset_valid", int'(warp_valid), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_reset_valid", int'(warp_valid), 0);
        check("async_reset_sel", int'(warp_select), 0);
        check("async_reset_pulse", int'(switch_pulse), 0);
        @(negedge clk);
        reset = 1'b0;

        // Two eligible warps with switch_ok held: only the timeout build rotates.
        start = 1'b1; warp_active = 4'h3; switch_ok = 1'b1;
        step();
        step();
        check("two_warp_sel", int'(warp_select), 1);
        check("two_warp_pulse", int'(switch_pulse), 1);
`ifdef WARP_ARBITER_TIMEOUT_EN
        step(); step(); step(); step();
        check("timeout_select_valid", int'(warp_valid), 0);
        step();
        check("timeout_sel", int'(warp_select), 0);
        check("timeout_pulse", int'(switch_pulse), 1);
        do_reset();
        start = 1'b1; warp_active = 4'h3; switch_ok = 1'b1;
        step();
        step();
        count_run("two_warp", 4);
`else
        count_run("two_warp", 0);
`endif

        // Single eligible warp never gets switched away.
        do_reset();
        start = 1'b1; warp_active = 4'h2; switch_ok = 1'b1;
        step();
        step();
        check("one_warp_sel", int'(warp_select), 1);
        count_run("one_warp", 0);
        check("one_warp_sel_end", int'(warp_select), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/warp_arbiter.md
WARP_ARBITER -- requirements
Module: warp_arbiter

Interface
REQ-001 Parameter NUM_WARPS, default 4: number of warps sharing one core's pipeline; power of two, 2..8.
REQ-002 Parameter MAX_RUN, default 16: cycle budget per warp residency (timeout feature only); 2..255.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  kernel launched; level, held high until all_done observed.
REQ-006 warp_active  in  NUM_WARPS  warp has a block assigned.
REQ-007 warp_stall  in  NUM_WARPS  warp blocked on fetcher or LSU.
REQ-008 warp_done  in  NUM_WARPS  warp executed RET; sticky until start drops.
REQ-009 switch_ok  in  1  current warp's scheduler is at a safe switch point (FETCH, WAIT or DONE).
REQ-010 warp_select  out  $clog2(NUM_WARPS)  index of warp owning the pipeline.
REQ-011 warp_valid  out  1  warp_select is live and the pipeline may advance.
REQ-012 switch_pulse  out  1  one-cycle strobe when warp_select changes value.
REQ-013 all_done  out  1  every active warp has finished.

Function
REQ-014 Eligible(i) = warp_active[i] & ~warp_done[i] & ~warp_stall[i]; Pending(i) = warp_active[i] & ~warp_done[i].
REQ-015 States: IDLE, SELECT, RUN, DONE; all outputs registered.
REQ-016 IDLE: warp_valid=0, all_done=0; start=1 -> SELECT next cycle.
REQ-017 SELECT: round-robin search from warp_select+1 upward, wrapping modulo NUM_WARPS, current warp checked last; first Eligible index is loaded into warp_select and state -> RUN.
REQ-018 SELECT with no Eligible warp and at least one Pending warp: stay in SELECT, warp_valid=0, warp_select unchanged.
REQ-019 SELECT with no Pending warp (including warp_active all zero): -> DONE.
REQ-020 switch_pulse=1 in the cycle after SELECT only if the newly loaded index differs from the previous warp_select; re-selection of the same warp gives no pulse.
REQ-021 RUN: warp_valid=1; selection latency from SELECT entry to warp_valid is exactly 1 cycle.
REQ-022 RUN -> SELECT when warp_done[warp_select]=1, regardless of switch_ok.
REQ-023 RUN -> SELECT when warp_stall[warp_select]=1 and switch_ok=1; stall without switch_ok holds RUN.
REQ-024 warp_valid drops to 0 in the cycle RUN exits.
REQ-025 Simultaneous done and stall on current warp: treated as done.
REQ-026 DONE: all_done=1, warp_valid=0; start=0 -> IDLE, all_done clears next cycle.
REQ-027 start=0 in SELECT or RUN: -> IDLE next cycle, warp_valid=0, warp_select retained, no pulse.
REQ-028 Input changes to non-selected warps never disturb RUN except via the timeout feature.

Reset
REQ-029 Reset assertion asynchronously forces state=IDLE, warp_select=0, warp_valid=0, switch_pulse=0, all_done=0, run counter=0.
REQ-030 Reset asserted mid-RUN aborts residency with no pulse; after release, behaviour is identical to power-up.

Configuration
REQ-031 Macro WARP_ARBITER_TIMEOUT_EN enables the residency timeout.
REQ-032 With macro: 8-bit run counter clears on RUN entry, increments each RUN cycle, saturates at MAX_RUN-1.
REQ-033 With macro: counter at MAX_RUN-1, switch_ok=1 and another warp Eligible -> SELECT; no other Eligible warp -> stay in RUN, counter saturated.
REQ-034 Without macro: no counter present; RUN exits only per REQ-022/023/027.

Verification
REQ-035 Reset then start=1, warp_active=4'b1111, none stalled -> RUN with warp_select=1 two cycles after start, switch_pulse=1 once.
REQ-036 In RUN on warp 1, warp_stall=4'b0010, switch_ok=1 -> warp_select=2 after SELECT, switch_pulse=1; with switch_ok=0 warp_select stays 1.
REQ-037 warp_active=4'b0101, warp 2 stalled, warp 0 done -> SELECT holds, warp_valid=0 until warp 2 unstalls, then warp_select=2.
REQ-038 Set warp_done one warp at a time until 4'b1111 -> DONE, all_done=1; drop start -> IDLE, all_done=0.
REQ-039 With WARP_ARBITER_TIMEOUT_EN, MAX_RUN=4, two eligible warps, switch_ok=1 -> warp_select alternates every 5 cycles (4 RUN + 1 SELECT); single eligible warp -> no switch.
REQ-040 Assert reset mid-RUN between clock edges -> warp_valid=0 immediately, warp_select=0.
